md_sched: RTL

Multiply/divide sequencer for the P6 pipeline. Sits between the E-stage decode and the HI/LO arithmetic core. It accepts one mult/div/mthi/mtlo operation at a time, launches the core, and counts the fixed latency of the operation. It generates the HI/LO write strobes and the D-stage stall for any instruction that touches HI/LO while an operation is in flight.

---
 rtl/md_if.sv | 28 ++
 rtl/md_sched.sv | 114 +++++++++++
 2 files changed

// File: rtl/md_if.sv
// Bundle of E-stage request, D-stage hazard and HI/LO control signals
// between the decode pipeline and the multiply/divide sequencer.
interface md_if;
  logic       e_valid;
  logic [2:0] e_op;
  logic       d_md_use;
  logic       md_start;
  logic [2:0] md_mode;
  logic       md_busy;
  logic       md_done;
  logic       hilo_we;
  logic       hi_we;
  logic       lo_we;
  logic       stall_d;
  logic       op_drop;

  modport master (
    output e_valid, e_op, d_md_use,
    input  md_start, md_mode, md_busy, md_done, hilo_we, hi_we, lo_we,
           stall_d, op_drop
  );

  modport slave (
    input  e_valid, e_op, d_md_use,
    output md_start, md_mode, md_busy, md_done, hilo_we, hi_we, lo_we,
           stall_d, op_drop
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencer: launches the HI/LO core, counts fixed latency,
// raises HI/LO write strobes and the D-stage stall while an op is in flight.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  md_if.slave        bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             rst_q;

  logic       start, busy, done, hi, lo, drop, blk, op_real;
  logic [2:0] mode;

  // Outputs stay quiet in the reset cycle and the one after it.
  assign blk     = reset | rst_q;
  assign op_real = (bus.e_op != 3'b000) && (bus.e_op != 3'b111);

  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    start   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    hi      = 1'b0;
    lo      = 1'b0;
    drop    = 1'b0;
    mode    = 3'b000;
    case (state_q)
      IDLE: begin
        if (bus.e_valid && !blk) begin
          case (bus.e_op)
            3'b001, 3'b010: begin
              start   = 1'b1;
              mode    = bus.e_op;
              mode_d  = bus.e_op;
              state_d = MUL;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
            end
            3'b011, 3'b100: begin
              start   = 1'b1;
              mode    = bus.e_op;
              mode_d  = bus.e_op;
              state_d = DIV;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
            end
            3'b101:  hi = 1'b1;
            3'b110:  lo = 1'b1;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        busy = 1'b1;
        mode = mode_q;
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        // Only reachable when the stall is bypassed; the op is discarded.
        if (bus.e_valid && op_real) drop = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (blk) begin
      start = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      drop  = 1'b0;
      mode  = 3'b000;
    end
  end

  assign bus.md_start = start;
  assign bus.md_mode  = mode;
  assign bus.md_busy  = busy;
  assign bus.md_done  = done;
  assign bus.hilo_we  = done;
  assign bus.hi_we    = hi;
  assign bus.lo_we    = lo;
  assign bus.op_drop  = drop;
  assign bus.stall_d  = bus.d_md_use & (busy | start);
  assign dbg_state_o  = state_q;

endmodule
